// File: rtl/md5_iter_engine.sv
// md5_iter_engine: single-block MD5 hasher with on-the-fly padding, RPC steps per clock,
// digest compare against a target latched with the candidate.
`default_nettype none

module md5_iter_engine #(
    parameter  int MAX_LEN = 16,
    parameter  int RPC     = 1,
    parameter  int TAG_W   = 32,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*MAX_LEN-1:0] in_guess,
    input  logic [LEN_W-1:0]     in_len,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic [127:0]         in_target,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_digest,
    output logic                 out_match,
    output logic [TAG_W-1:0]     out_tag
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [5:0] LAST_CNT = 6'(64 - RPC);

    localparam logic [31:0] K_TAB [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Indexed by {round, step mod 4}.
    localparam logic [4:0] S_TAB [0:15] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    logic [1:0]         state;
    logic [5:0]         cnt;
    logic [31:0]        a, b, c, d;
    logic [15:0][31:0]  msg;
    logic [TAG_W-1:0]   tag_q;
    logic [127:0]       target_q;

    logic [LEN_W-1:0]   len_c;
    logic [31:0]        len32;
    logic [55:0][7:0]   msg_byte;
    logic [15:0][31:0]  msg_in;

    assign len_c  = (in_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : in_len;
    assign len32  = 32'(len_c);

    // Packed byte 0 lands in the low bits of word 0, giving little-endian words directly.
    for (genvar i = 0; i < 56; i++) begin : g_byte
        if (i < MAX_LEN) begin : g_guess
            assign msg_byte[i] = (len32 > 32'(i)) ? in_guess[8*(MAX_LEN-1-i) +: 8] :
                                 (len32 == 32'(i)) ? 8'h80 : 8'h00;
        end else begin : g_pad
            assign msg_byte[i] = (len32 == 32'(i)) ? 8'h80 : 8'h00;
        end
    end

    assign msg_in = {32'h0, len32[28:0], 3'b000, msg_byte};

    logic [31:0] na, nb, nc, nd;
    logic [31:0] fn, sum, rot, tmp;
    logic [5:0]  j;
    logic [3:0]  idx;
    logic [4:0]  sh;

    always_comb begin
        na  = a;
        nb  = b;
        nc  = c;
        nd  = d;
        fn  = '0;
        sum = '0;
        rot = '0;
        tmp = '0;
        j   = '0;
        idx = '0;
        sh  = '0;
        for (int k = 0; k < RPC; k++) begin
            j = cnt + 6'(k);
            case (j[5:4])
                2'd0: begin fn = (nb & nc) | (~nb & nd); idx = j[3:0];                end
                2'd1: begin fn = (nb & nd) | (nc & ~nd); idx = j[3:0] * 4'd5 + 4'd1; end
                2'd2: begin fn = nb ^ nc ^ nd;           idx = j[3:0] * 4'd3 + 4'd5; end
                default: begin fn = nc ^ (nb | ~nd);     idx = j[3:0] * 4'd7;        end
            endcase
            sh  = S_TAB[{j[5:4], j[1:0]}];
            sum = na + fn + msg[idx] + K_TAB[j];
            rot = (sum << sh) | (sum >> (6'd32 - {1'b0, sh}));
            tmp = nd;
            nd  = nc;
            nc  = nb;
            nb  = nb + rot;
            na  = tmp;
        end
    end

    logic [127:0] digest_c;
    assign digest_c = {bswap(na + IV_A), bswap(nb + IV_B), bswap(nc + IV_C), bswap(nd + IV_D)};

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            d          <= '0;
            msg        <= '0;
            tag_q      <= '0;
            target_q   <= '0;
            out_digest <= '0;
            out_match  <= 1'b0;
            out_tag    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        msg      <= msg_in;
                        tag_q    <= in_tag;
                        target_q <= in_target;
                        a        <= IV_A;
                        b        <= IV_B;
                        c        <= IV_C;
                        d        <= IV_D;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a   <= na;
                    b   <= nb;
                    c   <= nc;
                    d   <= nd;
                    cnt <= cnt + 6'(RPC);
                    if (cnt == LAST_CNT) begin
                        out_digest <= digest_c;
                        out_match  <= (digest_c == target_q);
                        out_tag    <= tag_q;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_md5_iter_engine.sv
// Directed bench for md5_iter_engine: RPC=1 and RPC=4 instances against known MD5 vectors.
`default_nettype none

module tb_md5_iter_engine;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RPC=1 instance
    logic         rst1, in_valid1, in_ready1, out_valid1, out_ready1, out_match1;
    logic [127:0] in_guess1, in_target1, out_digest1;
    logic [4:0]   in_len1;
    logic [31:0]  in_tag1, out_tag1;

    // RPC=4 instance
    logic         rst4, in_valid4, in_ready4, out_valid4, out_ready4, out_match4;
    logic [127:0] in_guess4, in_target4, out_digest4;
    logic [4:0]   in_len4;
    logic [31:0]  in_tag4, out_tag4;

    md5_iter_engine #(.MAX_LEN(16), .RPC(1), .TAG_W(32)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_guess(in_guess1), .in_len(in_len1), .in_tag(in_tag1), .in_target(in_target1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_digest(out_digest1),
        .out_match(out_match1), .out_tag(out_tag1)
    );

    md5_iter_engine #(.MAX_LEN(16), .RPC(4), .TAG_W(32)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_guess(in_guess4), .in_len(in_len4), .in_tag(in_tag4), .in_target(in_target4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_digest(out_digest4),
        .out_match(out_match4), .out_tag(out_tag4)
    );

    localparam logic [127:0] H_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] H_A     = 128'h0cc175b9c0f1b6a831c399e269772661;
    localparam logic [127:0] H_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] H_MSG   = 128'hf96b697d7cb7938d525a2f31aaf161d0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack(input string s, input logic [7:0] fill);
        logic [127:0] g;
        for (int i = 0; i < 16; i++) g[8*(15-i) +: 8] = (i < s.len()) ? s[i] : fill;
        return g;
    endfunction

    // Reference MD5 of the first len bytes of a 16-byte guess (used for the length clamp case).
    localparam logic [31:0] RK [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a,
        32'ha8304613, 32'hfd469501, 32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821, 32'hf61e2562, 32'hc040b340,
        32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8,
        32'h676f02d9, 32'h8d2a4c8a, 32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70, 32'h289b7ec6, 32'heaa127fa,
        32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92,
        32'hffeff47d, 32'h85845dd1, 32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    localparam int RS [0:15] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    function automatic logic [31:0] bs(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [127:0] ref_md5(input logic [127:0] g, input int len);
        logic [7:0]  blk [64];
        logic [31:0] w [16];
        logic [31:0] a, b, c, d, f, t;
        int          gi, r;
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;
        for (int i = 0; i < len; i++) blk[i] = g[8*(15-i) +: 8];
        blk[len] = 8'h80;
        blk[56]  = 8'(len * 8);
        blk[57]  = 8'((len * 8) >> 8);
        for (int i = 0; i < 16; i++) w[i] = {blk[4*i+3], blk[4*i+2], blk[4*i+1], blk[4*i]};
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); gi = i;                end
            else if (i < 32) begin f = (d & b) | (~d & c); gi = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          gi = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       gi = (7 * i) % 16;     end
            r = RS[(i / 16) * 4 + (i % 4)];
            f = f + a + RK[i] + w[gi];
            t = d; d = c; c = b;
            b = b + ((f << r) | (f >> (32 - r)));
            a = t;
        end
        return {bs(a + 32'h67452301), bs(b + 32'hefcdab89), bs(c + 32'h98badcfe), bs(d + 32'h10325476)};
    endfunction

    task automatic send1(input logic [127:0] g, input logic [4:0] len, input logic [31:0] tag,
                         input logic [127:0] tgt);
        in_guess1 = g; in_len1 = len; in_tag1 = tag; in_target1 = tgt; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
    endtask

    task automatic send4(input logic [127:0] g, input logic [4:0] len, input logic [31:0] tag,
                         input logic [127:0] tgt);
        in_guess4 = g; in_len4 = len; in_tag4 = tag; in_target4 = tgt; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
    endtask

    task automatic wait1(output int n);
        n = 0;
        while (out_valid1 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic wait4(output int n);
        n = 0;
        while (out_valid4 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic drain1;
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
    endtask

    task automatic drain4;
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
    endtask

    initial begin
        int           n;
        logic         seen;
        logic [127:0] g;

        rst1 = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b0;
        in_guess1 = '0; in_len1 = '0; in_tag1 = '0; in_target1 = '0;
        rst4 = 1'b1; in_valid4 = 1'b0; out_ready4 = 1'b0;
        in_guess4 = '0; in_len4 = '0; in_tag4 = '0; in_target4 = '0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready1, 1'b0);
        check("rst_out_valid", out_valid1, 1'b0);
        check("rst_out_match", out_match1, 1'b0);
        check("rst_out_digest", out_digest1, 128'h0);
        check("rst_out_tag", out_tag1, 32'h0);
        check("rst4_in_ready", in_ready4, 1'b0);
        rst1 = 1'b0; rst4 = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready1, 1'b1);
        check("post_rst4_in_ready", in_ready4, 1'b1);
        @(negedge clk);

        // Empty message, matching target, exact latency
        send1(128'h0, 5'd0, 32'h000000a5, H_EMPTY);
        check("empty_busy", in_ready1, 1'b0);
        wait1(n);
        check("empty_latency", 128'(n), 128'd64);
        check("empty_digest", out_digest1, H_EMPTY);
        check("empty_match", out_match1, 1'b1);
        check("empty_tag", out_tag1, 32'h000000a5);
        drain1();
        check("empty_drained", out_valid1, 1'b0);

        // "abc" with 0xFF garbage beyond len, non-matching target
        send1(pack("abc", 8'hff), 5'd3, 32'h00000002, H_A);
        wait1(n);
        check("abc_digest", out_digest1, H_ABC);
        check("abc_match", out_match1, 1'b0);
        check("abc_tag", out_tag1, 32'h00000002);

        // Backpressure: next candidate waits while the result is held
        in_guess1 = pack("message digest", 8'h5a); in_len1 = 5'd14;
        in_tag1 = 32'h00000003; in_target1 = H_MSG; in_valid1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid1, 1'b1);
            check("bp_digest", out_digest1, H_ABC);
            check("bp_tag", out_tag1, 32'h00000002);
            check("bp_in_ready", in_ready1, 1'b0);
        end
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check("bp_release_valid", out_valid1, 1'b0);
        check("bp_release_ready", in_ready1, 1'b1);
        @(negedge clk);
        in_valid1 = 1'b0;
        check("bp_second_accepted", in_ready1, 1'b0);
        wait1(n);
        check("msg1_latency", 128'(n), 128'd64);
        check("msg1_digest", out_digest1, H_MSG);
        check("msg1_match", out_match1, 1'b1);
        check("msg1_tag", out_tag1, 32'h00000003);
        drain1();

        // Reset in the middle of RUN
        send1(pack("abc", 8'h00), 5'd3, 32'h00000005, H_ABC);
        repeat (29) @(negedge clk);
        rst1 = 1'b1;
        #1;
        check("midrst_in_ready_low", in_ready1, 1'b0);
        @(negedge clk);
        rst1 = 1'b0;
        #1;
        check("midrst_in_ready_high", in_ready1, 1'b1);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid1 === 1'b1) seen = 1'b1;
        end
        check("midrst_no_result", seen, 1'b0);
        send1(pack("abc", 8'h00), 5'd3, 32'h00000006, H_ABC);
        wait1(n);
        check("midrst_next_digest", out_digest1, H_ABC);
        check("midrst_next_match", out_match1, 1'b1);
        check("midrst_next_tag", out_tag1, 32'h00000006);
        drain1();

        // Over-length in_len clamps to MAX_LEN
        g = pack("0123456789abcdef", 8'h00);
        send1(g, 5'd19, 32'h00000007, ref_md5(g, 16));
        wait1(n);
        check("clamp_digest", out_digest1, ref_md5(g, 16));
        check("clamp_match", out_match1, 1'b1);
        drain1();

        // RPC=4 instance
        send4(pack("a", 8'hc3), 5'd1, 32'h00000011, 128'h0);
        wait4(n);
        check("rpc4_a_latency", 128'(n), 128'd16);
        check("rpc4_a_digest", out_digest4, H_A);
        check("rpc4_a_match", out_match4, 1'b0);
        check("rpc4_a_tag", out_tag4, 32'h00000011);
        drain4();
        check("rpc4_drained", out_valid4, 1'b0);
        send4(pack("message digest", 8'h00), 5'd14, 32'h00000012, H_MSG);
        wait4(n);
        check("rpc4_msg_digest", out_digest4, H_MSG);
        check("rpc4_msg_match", out_match4, 1'b1);
        check("rpc4_msg_tag", out_tag4, 32'h00000012);
        drain4();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/md5_iter_engine.md
# md5_iter_engine

Parametrised iterative MD5 hash engine for the FPGA cracker. It accepts one padded-on-the-fly candidate of up to MAX_LEN bytes over a valid/ready handshake and runs the 64 MD5 steps at RPC steps per clock. It adds the IV to produce the digest and compares that digest against a target sampled with the candidate. Several instances sit behind the guess generator; the match flag and tag feed the result collector.

## Interface
Parameters:
- MAX_LEN, 16: maximum candidate length in bytes; legal 1..55.
- RPC, 1: MD5 steps per clock; legal 1, 2, 4, 8, 16.
- TAG_W, 32: width of the candidate tag carried through to the result.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  candidate present.
- in_ready  out  1  engine can accept a candidate.
- in_guess  in  8*MAX_LEN  candidate bytes; byte 0 in in_guess[8*MAX_LEN-1 -: 8].
- in_len  in  $clog2(MAX_LEN+1)  candidate length in bytes; values > MAX_LEN are treated as MAX_LEN.
- in_tag  in  TAG_W  opaque candidate ID.
- in_target  in  128  digest to match, in standard byte order.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_digest  out  128  MD5 digest; digest byte 0 (low byte of A) in [127:120].
- out_match  out  1  out_digest == latched target.
- out_tag  out  TAG_W  tag of the hashed candidate.

## Operation
- Message block M[0..15], 32-bit little-endian words.
  - Guess byte i goes to M[i/4] bits [8*(i%4)+7 : 8*(i%4)].
  - Byte 0x80 goes at position len.
  - All other bytes are zero.
  - M[14] = len*8; M[15] = 0.
  - Single block only.
- FSM states IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - Latch M, tag and target.
  - Load A,B,C,D = 67452301, efcdab89, 98badcfe, 10325476.
  - Clear the step counter; go to RUN.
- RUN: each cycle performs steps j..j+RPC-1 combinationally chained, then counter += RPC.
  - Step j uses standard MD5:
    - F/G/H/I selection: j/16.
    - Message index: j, (5j+1), (3j+5), 7j mod 16.
    - Shift table s and constant T[j] = floor(|sin(j+1)|·2^32).
  - Rotate: new B = B + rotl(A + fn + M[idx] + T, s); then A←D, D←C, C←B.
  - All arithmetic is mod 2^32.
  - On the cycle with counter == 64-RPC:
    - out_digest ← byte-swapped {A+IV_A, B+IV_B, C+IV_C, D+IV_D}.
    - out_match ← (that value == target).
    - out_tag ← tag; go to DONE.
- DONE: out_valid=1 and in_ready=0; out_digest, out_match and out_tag are stable.
  - On out_ready: go to IDLE and drop out_valid.
  - No input is accepted in the same cycle.
- in_guess bytes at index ≥ len are ignored; they are overwritten by padding or zeros.
- Reset asserted at any time: state→IDLE, counter 0, any in-flight candidate discarded, no result emitted.

## Timing
- Reset values:
  - in_ready=0 while rst high, 1 in the first cycle after deassertion.
  - out_valid=0, out_match=0, out_digest=0, out_tag=0.
- Latency: accept at edge N → out_valid high after edge N+64/RPC; 64 cycles for RPC=1, 16 cycles for RPC=4.
- Throughput: one candidate per 64/RPC+2 cycles when out_ready is held high (accept, RUN, DONE, IDLE).
- in_ready depends only on state and rst; it is not combinational on in_valid.
- out_valid never drops without out_ready; outputs never change while out_valid=1.
- in_valid and out_ready are never required to be high at any particular time; stalls of any length are legal.

## Test plan
- RPC=1, len=0 → out_digest=d41d8cd98f00b204e9800998ecf8427e, out_valid exactly 64 cycles after accept; target set to that value → out_match=1.
- "abc" (len=3, trailing bytes 0xFF) → 900150983cd24fb0d6963f7d28e17f72; target = "a" digest → out_match=0; garbage bytes have no effect.
- RPC=4, "a" → 0cc175b9c0f1b6a831c399e269772661 after 16 cycles; "message digest" (len=14) → f96b697d7cb7938d525a2f31aaf161d0.
- Backpressure: out_ready low 10 cycles in DONE → out_valid, digest and tag stable, in_ready=0; release → back-to-back second candidate accepted two cycles later with the correct tag.
- Reset mid-RUN (step 30) → out_valid never rises, in_ready=1 after release; next candidate "abc" hashes correctly.
- in_len=MAX_LEN+3 with MAX_LEN=16 → result equals the hash of the 16-byte guess.
